// File: rtl/pwm_duty_calc.sv
// PWM duty calculator: per-mille duty via restoring divider,
// windowed average, period length, drop and staleness tracking.
module pwm_duty_calc #(
    parameter int AVG_LOG2       = 4,
    parameter int MIN_PERIOD     = 2,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic        pwd_clk,
    input  logic        sysreset,
    input  logic [31:0] high_count,
    input  logic [31:0] low_count,
    input  logic        count_valid,
    output logic        busy,
    output logic [9:0]  duty_inst,
    output logic [9:0]  duty_avg,
    output logic [31:0] period_cycles,
    output logic        duty_valid,
    output logic        err_short,
    output logic        stale,
    output logic [7:0]  drop_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;

    localparam int AW = 10 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] WIN = CW'(1 << AVG_LOG2);

    logic [1:0]    state_q, state_d;
    logic [41:0]   num_q, num_d;
    logic [32:0]   den_q, den_d;
    logic [32:0]   rem_q, rem_d;
    logic [41:0]   quo_q, quo_d;
    logic [5:0]    bit_q, bit_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    inst_q, inst_d;
    logic [9:0]    avg_q, avg_d;
    logic [31:0]   per_q, per_d;
    logic          dv_q, dv_d;
    logic          err_q, err_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [7:0]    drop_q, drop_d;

    logic [32:0]   sum;
    logic [33:0]   rem_sh;
    logic [9:0]    q_clamp;
    logic [AW-1:0] acc_new;
    logic [CW-1:0] cnt_new;
    logic          accept;

    // Next-state logic: accept/reject, divide step, accumulate, counters
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        bit_d   = bit_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        avg_d   = avg_q;
        per_d   = per_q;
        dv_d    = 1'b0;
        err_d   = err_q;
        drop_d  = drop_q;
        accept  = 1'b0;

        sum     = {1'b0, high_count} + {1'b0, low_count};
        rem_sh  = {rem_q, num_q[41]};
        q_clamp = (quo_q > 42'd1000) ? 10'd1000 : quo_q[9:0];
        acc_new = acc_q + AW'(q_clamp);
        cnt_new = cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (count_valid) begin
                    if (sum < 33'(MIN_PERIOD)) begin
                        err_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        num_d   = 42'(high_count) * 42'd1000;
                        den_d   = sum;
                        rem_d   = '0;
                        quo_d   = '0;
                        bit_d   = '0;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                num_d = {num_q[40:0], 1'b0};
                if (rem_sh >= {1'b0, den_q}) begin
                    rem_d = rem_sh[32:0] - den_q;
                    quo_d = {quo_q[40:0], 1'b1};
                end else begin
                    rem_d = rem_sh[32:0];
                    quo_d = {quo_q[40:0], 1'b0};
                end
                bit_d = bit_q + 1'b1;
                if (bit_q == 6'd41) state_d = S_ACC;
            end
            S_ACC: begin
                inst_d  = q_clamp;
                per_d   = den_q[32] ? 32'hFFFF_FFFF : den_q[31:0];
                err_d   = 1'b0;
                if (cnt_new == WIN) begin
                    avg_d = 10'(acc_new >> AVG_LOG2);
                    dv_d  = 1'b1;
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = acc_new;
                    cnt_d = cnt_new;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (count_valid && state_q != S_IDLE && drop_q != 8'hFF)
            drop_d = drop_q + 1'b1;

        if (accept)
            tmo_d = '0;
        else if (tmo_q != 32'hFFFF_FFFF)
            tmo_d = tmo_q + 1'b1;
        else
            tmo_d = tmo_q;
    end

    // State registers; reset aborts any in-flight sample
    always_ff @(posedge pwd_clk or posedge sysreset) begin
        if (sysreset) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            bit_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            inst_q  <= '0;
            avg_q   <= '0;
            per_q   <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            bit_q   <= bit_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            avg_q   <= avg_d;
            per_q   <= per_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            drop_q  <= drop_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign duty_inst     = inst_q;
    assign duty_avg      = avg_q;
    assign period_cycles = per_q;
    assign duty_valid    = dv_q;
    assign err_short     = err_q;
    assign stale         = (tmo_q >= 32'(TIMEOUT_CYCLES));
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_pwm_duty_calc.sv
// Directed bench for pwm_duty_calc: two instances (window 1 and 4)
// share stimulus; vector table plus multi-cycle corner sequences.
module tb_pwm_duty_calc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] high_count;
    logic [31:0] low_count;
    logic        cv;

    logic        busy0, dv0, err0, stale0;
    logic [9:0]  inst0, avg0;
    logic [31:0] per0;
    logic [7:0]  drop0;
    logic        busy2, dv2, err2, stale2;
    logic [9:0]  inst2, avg2;
    logic [31:0] per2;
    logic [7:0]  drop2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_duty_calc #(.AVG_LOG2(0), .MIN_PERIOD(2), .TIMEOUT_CYCLES(50)) dut0 (
        .pwd_clk(clk), .sysreset(rst),
        .high_count(high_count), .low_count(low_count), .count_valid(cv),
        .busy(busy0), .duty_inst(inst0), .duty_avg(avg0),
        .period_cycles(per0), .duty_valid(dv0), .err_short(err0),
        .stale(stale0), .drop_count(drop0)
    );

    pwm_duty_calc #(.AVG_LOG2(2), .MIN_PERIOD(2), .TIMEOUT_CYCLES(50)) dut2 (
        .pwd_clk(clk), .sysreset(rst),
        .high_count(high_count), .low_count(low_count), .count_valid(cv),
        .busy(busy2), .duty_inst(inst2), .duty_avg(avg2),
        .period_cycles(per2), .duty_valid(dv2), .err_short(err2),
        .stale(stale2), .drop_count(drop2)
    );

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic        err;
        logic [9:0]  duty;
        logic [31:0] per;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns 1ns after the accepting edge with the strobe already lowered
    task automatic strobe(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        high_count = h;
        low_count  = l;
        cv         = 1'b1;
        @(posedge clk);
        #1 cv = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'd100, 32'd900, 1'b0, 10'd100, 32'd1000};
        vecs[1]  = '{32'd200, 32'd800, 1'b0, 10'd200, 32'd1000};
        vecs[2]  = '{32'd300, 32'd700, 1'b0, 10'd300, 32'd1000};
        vecs[3]  = '{32'd401, 32'd599, 1'b0, 10'd401, 32'd1000};
        vecs[4]  = '{32'd250, 32'd750, 1'b0, 10'd250, 32'd1000};
        vecs[5]  = '{32'd0, 32'd40, 1'b0, 10'd0, 32'd40};
        vecs[6]  = '{32'd40, 32'd0, 1'b0, 10'd1000, 32'd40};
        vecs[7]  = '{32'd1, 32'd0, 1'b1, 10'd1000, 32'd40};
        vecs[8]  = '{32'd1, 32'd2, 1'b0, 10'd333, 32'd3};
        vecs[9]  = '{32'd2, 32'd1, 1'b0, 10'd666, 32'd3};
        vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 10'd500, 32'hFFFF_FFFF};
        vecs[11] = '{32'd0, 32'd1, 1'b1, 10'd500, 32'hFFFF_FFFF};
        vecs[12] = '{32'd7, 32'd3, 1'b0, 10'd700, 32'd10};

        rst = 1'b1;
        cv = 1'b0;
        high_count = '0;
        low_count = '0;
        #12;
        chk("rst_inst", 32'(inst0), 0);
        chk("rst_avg", 32'(avg0), 0);
        chk("rst_per", per0, 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_dv", 32'(dv0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_stale", 32'(stale0), 0);
        chk("rst_drop", 32'(drop0), 0);
        @(negedge clk);
        rst = 1'b0;

        // Staleness with no strobes: rises on the 50th edge
        repeat (49) @(posedge clk);
        #1 chk("stale_49", 32'(stale0), 0);
        @(posedge clk);
        #1 chk("stale_50", 32'(stale0), 1);

        for (int i = 0; i < 13; i++) begin
            strobe(vecs[i].h, vecs[i].l);
            if (vecs[i].err) begin
                chk("err_flag", 32'(err0), 1);
                chk("err_busy", 32'(busy0), 0);
                chk("err_inst", 32'(inst0), 32'(vecs[i].duty));
                chk("err_per", per0, vecs[i].per);
            end else begin
                chk("acc_busy", 32'(busy0), 1);
                chk("acc_stale", 32'(stale0), 0);
                repeat (43) @(posedge clk);
                #1;
                chk("v_inst", 32'(inst0), 32'(vecs[i].duty));
                chk("v_avg", 32'(avg0), 32'(vecs[i].duty));
                chk("v_per", per0, vecs[i].per);
                chk("v_err", 32'(err0), 0);
                chk("v_dv", 32'(dv0), 1);
                chk("v_busy", 32'(busy0), 0);
                if (i < 3) chk("win_dv_early", 32'(dv2), 0);
                if (i == 3) begin
                    chk("win_dv", 32'(dv2), 1);
                    chk("win_avg", 32'(avg2), 250);
                end
                @(posedge clk);
                #1 chk("v_dv_pulse", 32'(dv0), 0);
            end
        end

        // Strobe while busy is dropped
        strobe(32'd600, 32'd400);
        repeat (9) @(posedge clk);
        strobe(32'd100, 32'd100);
        chk("drop_busy", 32'(busy0), 1);
        chk("drop_cnt", 32'(drop0), 1);
        repeat (33) @(posedge clk);
        #1 chk("drop_inst", 32'(inst0), 600);
        repeat (60) @(posedge clk);
        #1;
        chk("drop_inst_hold", 32'(inst0), 600);
        chk("drop_idle", 32'(busy0), 0);
        chk("drop_cnt_hold", 32'(drop0), 1);
        chk("stale_again", 32'(stale0), 1);

        // Reset mid-divide aborts the sample
        strobe(32'd900, 32'd100);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_inst", 32'(inst0), 0);
        chk("mid_rst_avg", 32'(avg2), 0);
        chk("mid_rst_per", per0, 0);
        chk("mid_rst_busy", 32'(busy0), 0);
        chk("mid_rst_drop", 32'(drop0), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            strobe(32'd500, 32'd500);
            repeat (43) @(posedge clk);
            #1;
            chk("post_inst", 32'(inst0), 500);
            chk("post_dv2", 32'(dv2), (k == 3) ? 1 : 0);
        end
        chk("post_avg2", 32'(avg2), 500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
